// File: rtl/mmu_tlbmaint_ctrl.sv
// TLB maintenance controller: sequences read/write/probe/index/invalidate ops
// onto the TLB port and reports completion status back to the MMU pipeline.
module mmu_tlbmaint_ctrl #(
  parameter int IDX_W       = 9,
  parameter int NUM_ENTRIES = 512
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cancel_mode_i_m,
  input  logic             tlbread_i_m,
  input  logic             tlbwrite_i_m,
  input  logic             tlbprobe_i_m,
  input  logic             tlbindexl_i_m,
  input  logic             tlbindexj_i_m,
  input  logic             tlbinvald_i_m,
  input  logic             tlbinvali_i_m,
  input  logic [IDX_W-1:0] mmc_idx_i,
  input  logic             cancel_i,
  output logic             f_stall_mmu_o,
  output logic             rr_stall_mmu_o,
  output logic             tlb_req_o,
  output logic [2:0]       tlb_op_o,
  output logic [IDX_W-1:0] tlb_idx_o,
  input  logic             tlb_ack_i,
  input  logic             tlb_hit_i,
  input  logic [IDX_W-1:0] tlb_hit_idx_i,
  output logic             mmc_e_o,
  output logic [IDX_W-1:0] mmc_idx_o,
  output logic             done_o
);

  localparam logic [2:0] OP_READ   = 3'd0;
  localparam logic [2:0] OP_WRITE  = 3'd1;
  localparam logic [2:0] OP_PROBE  = 3'd2;
  localparam logic [2:0] OP_INVALD = 3'd5;
  localparam logic [2:0] OP_INVALI = 3'd6;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_SWEEP, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             mode_q, mode_d;
  logic             mmc_e_q, mmc_e_d;
  logic [IDX_W-1:0] mmc_idx_q, mmc_idx_d;
  logic             err_pulse_q, err_pulse_d;

  logic [6:0] strb;
  logic       strb_onehot;
  logic       strb_multi;
  logic [2:0] op_enc;
  logic       is_rw_in;
  logic       range_err;
  logic       is_inval_q;

  // Strobe bit position doubles as the op encoding driven on tlb_op_o.
  assign strb = {tlbinvali_i_m, tlbinvald_i_m, tlbindexj_i_m, tlbindexl_i_m,
                 tlbprobe_i_m, tlbwrite_i_m, tlbread_i_m};
  assign strb_onehot = (strb != 7'd0) && ((strb & (strb - 7'd1)) == 7'd0);
  assign strb_multi  = (strb != 7'd0) && !strb_onehot;
  assign is_rw_in    = (op_enc == OP_READ) || (op_enc == OP_WRITE);
  assign range_err   = 32'(mmc_idx_i) >= 32'(NUM_ENTRIES);
  assign is_inval_q  = (op_q == OP_INVALD) || (op_q == OP_INVALI);

  always_comb begin
    op_enc = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (strb[i]) op_enc = 3'(i);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      op_q        <= 3'd0;
      idx_q       <= '0;
      mode_q      <= 1'b0;
      mmc_e_q     <= 1'b0;
      mmc_idx_q   <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      mode_q      <= mode_d;
      mmc_e_q     <= mmc_e_d;
      mmc_idx_q   <= mmc_idx_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  // Invalidates pass through ISSUE for one cycle without a request before
  // sweeping, which sets the accept-to-done latency of a full sweep.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    idx_d       = idx_q;
    mode_d      = mode_q;
    mmc_e_d     = mmc_e_q;
    mmc_idx_d   = mmc_idx_q;
    err_pulse_d = 1'b0;
    tlb_req_o   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (strb_multi) begin
          mmc_e_d     = 1'b1;
          mmc_idx_d   = '0;
          err_pulse_d = 1'b1;
        end else if (strb_onehot) begin
          op_d   = op_enc;
          mode_d = cancel_mode_i_m;
          idx_d  = is_rw_in ? mmc_idx_i : '0;
          if (is_rw_in && range_err) begin
            mmc_e_d   = 1'b1;
            mmc_idx_d = mmc_idx_i;
            state_d   = S_DONE;
          end else begin
            state_d = cancel_mode_i_m ? S_CHECK : S_ISSUE;
          end
        end
      end
      S_CHECK: begin
        state_d = (cancel_i && mode_q) ? S_IDLE : S_ISSUE;
      end
      S_ISSUE: begin
        if (is_inval_q) begin
          idx_d   = '0;
          state_d = S_SWEEP;
        end else begin
          tlb_req_o = 1'b1;
          if (tlb_ack_i) begin
            if (op_q == OP_PROBE) begin
              mmc_e_d   = ~tlb_hit_i;
              mmc_idx_d = tlb_hit_idx_i;
            end else begin
              mmc_e_d   = 1'b0;
              mmc_idx_d = idx_q;
            end
            state_d = S_DONE;
          end
        end
      end
      S_SWEEP: begin
        tlb_req_o = 1'b1;
        if (tlb_ack_i) begin
          if (idx_q == LAST_IDX) begin
            mmc_e_d   = 1'b0;
            mmc_idx_d = idx_q;
            state_d   = S_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign f_stall_mmu_o  = (state_q != S_IDLE);
  assign rr_stall_mmu_o = (state_q != S_IDLE);
  assign tlb_op_o       = op_q;
  assign tlb_idx_o      = idx_q;
  assign mmc_e_o        = mmc_e_q;
  assign mmc_idx_o      = mmc_idx_q;
  assign done_o         = (state_q == S_DONE) || err_pulse_q;

endmodule

// File: tb/tb_mmu_tlbmaint_ctrl.sv
// Directed bench: instance A (512 entries, 10-bit index) and instance B
// (8 entries, 4-bit index) share stimulus; sel_b routes strobes and results.
module tb_mmu_tlbmaint_ctrl;

  logic       clock;
  logic       reset;
  logic       sel_b;
  logic [6:0] strb;
  logic [6:0] strb_a, strb_b;
  logic       mode;
  logic [9:0] idx_in;
  logic       cancel;
  logic       ack;
  logic       hit;
  logic [9:0] hit_idx;

  logic       fst_a, rrst_a, req_a, e_a, done_a;
  logic [2:0] op_a;
  logic [9:0] tidx_a, midx_a;
  logic       fst_b, rrst_b, req_b, e_b, done_b;
  logic [2:0] op_b;
  logic [3:0] tidx_b, midx_b;

  logic       fst_s, rrst_s, req_s, e_s, done_s;
  logic [2:0] op_s;
  logic [9:0] tidx_s, midx_s;

  int n_cmp;
  int n_mis;

  assign strb_a = sel_b ? 7'd0 : strb;
  assign strb_b = sel_b ? strb : 7'd0;

  mmu_tlbmaint_ctrl #(.IDX_W(10), .NUM_ENTRIES(512)) dut_a (
    .clock(clock), .reset(reset), .cancel_mode_i_m(mode),
    .tlbread_i_m(strb_a[0]), .tlbwrite_i_m(strb_a[1]), .tlbprobe_i_m(strb_a[2]),
    .tlbindexl_i_m(strb_a[3]), .tlbindexj_i_m(strb_a[4]),
    .tlbinvald_i_m(strb_a[5]), .tlbinvali_i_m(strb_a[6]),
    .mmc_idx_i(idx_in), .cancel_i(cancel),
    .f_stall_mmu_o(fst_a), .rr_stall_mmu_o(rrst_a),
    .tlb_req_o(req_a), .tlb_op_o(op_a), .tlb_idx_o(tidx_a),
    .tlb_ack_i(ack), .tlb_hit_i(hit), .tlb_hit_idx_i(hit_idx),
    .mmc_e_o(e_a), .mmc_idx_o(midx_a), .done_o(done_a)
  );

  mmu_tlbmaint_ctrl #(.IDX_W(4), .NUM_ENTRIES(8)) dut_b (
    .clock(clock), .reset(reset), .cancel_mode_i_m(mode),
    .tlbread_i_m(strb_b[0]), .tlbwrite_i_m(strb_b[1]), .tlbprobe_i_m(strb_b[2]),
    .tlbindexl_i_m(strb_b[3]), .tlbindexj_i_m(strb_b[4]),
    .tlbinvald_i_m(strb_b[5]), .tlbinvali_i_m(strb_b[6]),
    .mmc_idx_i(idx_in[3:0]), .cancel_i(cancel),
    .f_stall_mmu_o(fst_b), .rr_stall_mmu_o(rrst_b),
    .tlb_req_o(req_b), .tlb_op_o(op_b), .tlb_idx_o(tidx_b),
    .tlb_ack_i(ack), .tlb_hit_i(hit), .tlb_hit_idx_i(hit_idx[3:0]),
    .mmc_e_o(e_b), .mmc_idx_o(midx_b), .done_o(done_b)
  );

  assign fst_s  = sel_b ? fst_b  : fst_a;
  assign rrst_s = sel_b ? rrst_b : rrst_a;
  assign req_s  = sel_b ? req_b  : req_a;
  assign e_s    = sel_b ? e_b    : e_a;
  assign done_s = sel_b ? done_b : done_a;
  assign op_s   = sel_b ? op_b   : op_a;
  assign tidx_s = sel_b ? {6'd0, tidx_b} : tidx_a;
  assign midx_s = sel_b ? {6'd0, midx_b} : midx_a;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req"},   req_s,  1'b0);
    chk({tag, "_fst"},   fst_s,  1'b0);
    chk({tag, "_rrst"},  rrst_s, 1'b0);
    chk({tag, "_done"},  done_s, 1'b0);
    chk({tag, "_op"},    op_s,   3'd0);
    chk({tag, "_tidx"},  tidx_s, 10'd0);
    chk({tag, "_mmce"},  e_s,    1'b0);
    chk({tag, "_mmidx"}, midx_s, 10'd0);
  endtask

  initial begin
    int exp_idx;
    int req_cnt;
    int done_at;
    int done_cnt;
    int stall_cnt;
    n_cmp = 0; n_mis = 0;
    reset = 1'b0; sel_b = 1'b0; strb = 7'd0; mode = 1'b0; idx_in = 10'd0;
    cancel = 1'b0; ack = 1'b0; hit = 1'b0; hit_idx = 10'd0;

    step(); step();
    chk_idle_outputs("rst_a");

    // READ idx 5, no-cancel, accepted on the first edge after reset release
    reset = 1'b1; strb = 7'b0000001; idx_in = 10'd5; mode = 1'b0;
    step();
    strb = 7'd0;
    chk("rd_req1", req_s, 1'b1);
    chk("rd_op", op_s, 3'd0);
    chk("rd_tidx", tidx_s, 10'd5);
    chk("rd_fst1", fst_s, 1'b1);
    chk("rd_done1", done_s, 1'b0);
    step();
    chk("rd_req2", req_s, 1'b1);
    chk("rd_rrst2", rrst_s, 1'b1);
    step();
    ack = 1'b1;
    chk("rd_req3", req_s, 1'b1);
    step();
    ack = 1'b0;
    chk("rd_done", done_s, 1'b1);
    chk("rd_mmce", e_s, 1'b0);
    chk("rd_mmidx", midx_s, 10'd5);
    chk("rd_fst_done", fst_s, 1'b1);
    chk("rd_req_done", req_s, 1'b0);
    step();
    chk("rd_done_off", done_s, 1'b0);
    chk("rd_fst_off", fst_s, 1'b0);
    chk("rd_rrst_off", rrst_s, 1'b0);

    // WRITE idx 3 cancelled in CHECK
    strb = 7'b0000010; idx_in = 10'd3; mode = 1'b1;
    step();
    strb = 7'd0; cancel = 1'b1;
    chk("cx_fst", fst_s, 1'b1);
    chk("cx_req_chk", req_s, 1'b0);
    step();
    cancel = 1'b0;
    chk("cx_fst_off", fst_s, 1'b0);
    chk("cx_req_after", req_s, 1'b0);
    chk("cx_done_after", done_s, 1'b0);
    step();
    chk("cx_done_late", done_s, 1'b0);
    chk("cx_req_late", req_s, 1'b0);
    chk("cx_mmce_kept", e_s, 1'b0);
    chk("cx_mmidx_kept", midx_s, 10'd5);

    // WRITE idx 9 with cancel allowed but not used; cancel in ISSUE is ignored
    strb = 7'b0000010; idx_in = 10'd9; mode = 1'b1;
    step();
    strb = 7'd0;
    chk("wr_chk_req", req_s, 1'b0);
    chk("wr_chk_fst", fst_s, 1'b1);
    step();
    chk("wr_req", req_s, 1'b1);
    chk("wr_op", op_s, 3'd1);
    chk("wr_tidx", tidx_s, 10'd9);
    cancel = 1'b1; ack = 1'b1;
    step();
    cancel = 1'b0; ack = 1'b0;
    chk("wr_done", done_s, 1'b1);
    chk("wr_mmidx", midx_s, 10'd9);
    step();

    // PROBE miss then hit
    mode = 1'b0; strb = 7'b0000100; hit = 1'b0; hit_idx = 10'd7;
    step();
    strb = 7'd0;
    chk("pm_req", req_s, 1'b1);
    chk("pm_op", op_s, 3'd2);
    chk("pm_tidx", tidx_s, 10'd0);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("pm_done", done_s, 1'b1);
    chk("pm_mmce", e_s, 1'b1);
    chk("pm_mmidx", midx_s, 10'd7);
    step();
    strb = 7'b0000100; hit = 1'b1; hit_idx = 10'd12;
    step();
    strb = 7'd0; ack = 1'b1;
    step();
    ack = 1'b0; hit = 1'b0;
    chk("ph_done", done_s, 1'b1);
    chk("ph_mmce", e_s, 1'b0);
    chk("ph_mmidx", midx_s, 10'd12);
    step();

    // READ and PROBE strobed together
    strb = 7'b0000101; idx_in = 10'd4;
    step();
    strb = 7'd0;
    chk("ms_done", done_s, 1'b1);
    chk("ms_mmce", e_s, 1'b1);
    chk("ms_mmidx", midx_s, 10'd0);
    chk("ms_req", req_s, 1'b0);
    chk("ms_fst", fst_s, 1'b0);
    step();
    chk("ms_done_off", done_s, 1'b0);

    // READ idx 600 on the 512-entry instance
    strb = 7'b0000001; idx_in = 10'd600;
    step();
    strb = 7'd0;
    chk("oor_req", req_s, 1'b0);
    chk("oor_done", done_s, 1'b1);
    chk("oor_mmce", e_s, 1'b1);
    chk("oor_mmidx", midx_s, 10'd600);
    chk("oor_fst", fst_s, 1'b1);
    step();
    chk("oor_fst_off", fst_s, 1'b0);
    chk("oor_req_off", req_s, 1'b0);

    // 8-entry instance: last legal index, then first illegal index
    sel_b = 1'b1;
    strb = 7'b0000001; idx_in = 10'd7;
    step();
    strb = 7'd0;
    chk("b7_req", req_s, 1'b1);
    chk("b7_tidx", tidx_s, 10'd7);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("b7_done", done_s, 1'b1);
    chk("b7_mmce", e_s, 1'b0);
    chk("b7_mmidx", midx_s, 10'd7);
    step();
    strb = 7'b0000001; idx_in = 10'd8;
    step();
    strb = 7'd0;
    chk("b8_req", req_s, 1'b0);
    chk("b8_done", done_s, 1'b1);
    chk("b8_mmce", e_s, 1'b1);
    chk("b8_mmidx", midx_s, 10'd8);
    step();

    // Full INVALI sweep with ack tied high
    strb = 7'b1000000; mode = 1'b0; ack = 1'b1;
    exp_idx = 0; req_cnt = 0; done_at = -1;
    step();
    strb = 7'd0;
    for (int k = 1; k <= 13; k++) begin
      if (req_s) begin
        chk("sw_tidx", tidx_s, 32'(exp_idx));
        exp_idx++;
        req_cnt++;
      end
      if (done_s && done_at < 0) done_at = k;
      step();
    end
    ack = 1'b0;
    chk("sw_reqs", 32'(req_cnt), 32'd8);
    chk("sw_done_at", 32'(done_at), 32'd10);
    chk("sw_mmce", e_s, 1'b0);
    chk("sw_idle_fst", fst_s, 1'b0);

    // INVALD interrupted by reset at sweep index 3
    strb = 7'b0100000; ack = 1'b1;
    step();
    strb = 7'd0;
    step(); step(); step(); step();
    chk("rs_tidx3", tidx_s, 10'd3);
    chk("rs_req3", req_s, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk_idle_outputs("rs_b");
    @(posedge clock);
    #1;
    ack = 1'b0;
    reset = 1'b1;
    done_cnt = 0; stall_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (done_s) done_cnt++;
      if (fst_s || req_s) stall_cnt++;
    end
    chk("rs_no_done", 32'(done_cnt), 32'd0);
    chk("rs_no_activity", 32'(stall_cnt), 32'd0);
    strb = 7'b0000001; idx_in = 10'd2;
    step();
    strb = 7'd0;
    chk("rs_rd_req", req_s, 1'b1);
    chk("rs_rd_tidx", tidx_s, 10'd2);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("rs_rd_done", done_s, 1'b1);
    chk("rs_rd_mmce", e_s, 1'b0);
    chk("rs_rd_mmidx", midx_s, 10'd2);
    step();
    chk("rs_rd_idle", fst_s, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mmu_tlbmaint_ctrl.md
MMU_TLBMAINT_CTRL -- requirements
Module: mmu_tlbmaint_ctrl

Interface
REQ-001 SHALL have parameter IDX_W, default 9: TLB index width.
REQ-002 SHALL have parameter NUM_ENTRIES, default 512: TLB entries, 2 <= NUM_ENTRIES <= 2**IDX_W.
REQ-003 SHALL have ports `clock` (in, 1, sole clock) and `reset` (in, 1): reset is asynchronous, active-low.
REQ-004 SHALL have `cancel_mode_i_m` (in, 1): 0=NO_CANCEL, 1=CANCEL_ALLOWED.
REQ-005 SHALL have op strobes (in, 1 each): `tlbread_i_m`, `tlbwrite_i_m`, `tlbprobe_i_m`, `tlbindexl_i_m`, `tlbindexj_i_m`, `tlbinvald_i_m`, `tlbinvali_i_m`.
REQ-006 SHALL have `mmc_idx_i` (in, IDX_W): operand index for read/write.
REQ-007 SHALL have `cancel_i` (in, 1): kills the pending op during the cancel window.
REQ-008 SHALL have stall outputs `f_stall_mmu_o` and `rr_stall_mmu_o` (out, 1 each).
REQ-009 SHALL have TLB port signals:
- `tlb_req_o` (out, 1)
- `tlb_op_o` (out, 3)
- `tlb_idx_o` (out, IDX_W)
- `tlb_ack_i` (in, 1)
- `tlb_hit_i` (in, 1)
- `tlb_hit_idx_i` (in, IDX_W)
REQ-010 SHALL have status outputs:
- `mmc_e_o` (out, 1): error/miss
- `mmc_idx_o` (out, IDX_W): result index
- `done_o` (out, 1): one-cycle completion pulse

Function
REQ-011 SHALL encode tlb_op_o: READ=0, WRITE=1, PROBE=2, INDEXL=3, INDEXJ=4, INVALD=5, INVALI=6.
REQ-012 SHALL implement FSM states IDLE, CHECK, ISSUE, SWEEP, DONE.
REQ-013 SHALL accept an op only in IDLE when exactly one strobe is high, capturing op, mmc_idx_i and cancel_mode_i_m.
REQ-014 SHALL, in IDLE with two or more strobes high, issue no request, set mmc_e_o=1 and mmc_idx_o=0, pulse done_o next cycle and stay IDLE.
REQ-015 SHALL treat READ/WRITE with captured index >= NUM_ENTRIES as error: no request, go to DONE with mmc_e_o=1 and mmc_idx_o=captured index.
REQ-016 SHALL go IDLE->CHECK on accept when captured mode is CANCEL_ALLOWED, and IDLE->ISSUE when NO_CANCEL.
REQ-017 SHALL, in CHECK (exactly one cycle), return to IDLE on cancel_i=1 with no request, no done_o and mmc_e_o unchanged; otherwise go to ISSUE.
REQ-018 SHALL ignore cancel_i outside CHECK and always when the captured mode is NO_CANCEL.
REQ-019 SHALL, in ISSUE, hold tlb_req_o=1 with stable tlb_op_o/tlb_idx_o until tlb_ack_i=1, with no timeout.
REQ-020 SHALL drive tlb_idx_o = captured index for READ/WRITE and 0 for PROBE/INDEXL/INDEXJ.
REQ-021 SHALL handle INVALD/INVALI by entering SWEEP with tlb_idx_o=0.
REQ-022 SHALL, in SWEEP, keep tlb_req_o=1 and increment tlb_idx_o by 1 per acked cycle; ack at index NUM_ENTRIES-1 goes to DONE, and the index SHALL never wrap or exceed NUM_ENTRIES-1.
REQ-023 SHALL update status on ack in ISSUE:
- PROBE: mmc_e_o = ~tlb_hit_i, mmc_idx_o = tlb_hit_idx_i
- all other ops: mmc_e_o=0, mmc_idx_o=tlb_idx_o
REQ-024 SHALL, in DONE (one cycle), pulse done_o=1 and then return to IDLE; mmc_e_o/mmc_idx_o hold until the next completion.
REQ-025 SHALL assert f_stall_mmu_o and rr_stall_mmu_o combinationally whenever state != IDLE, and deassert both in the IDLE cycle after DONE.
REQ-026 SHALL ignore strobes arriving while state != IDLE.
REQ-027 SHALL make full-sweep latency NUM_ENTRIES+2 cycles from accept to done_o with ack tied high under NO_CANCEL, plus 1 cycle under CANCEL_ALLOWED.

Reset
REQ-028 SHALL, on reset=0, asynchronously set:
- state=IDLE
- all outputs 0: tlb_req_o, tlb_op_o, tlb_idx_o, stalls, mmc_e_o, mmc_idx_o, done_o
- captured op, index and mode cleared
REQ-029 SHALL abandon any in-flight op or sweep on reset, with no done_o after release.
REQ-030 SHALL accept a new op in the first clock edge after reset deasserts.

Verification
REQ-031 NO_CANCEL READ, idx=5, ack 2 cycles after req -> tlb_op_o=0, tlb_idx_o=5; done_o one cycle after ack; mmc_e_o=0, mmc_idx_o=5; stalls high accept+1..done.
REQ-032 CANCEL_ALLOWED WRITE idx=3, cancel_i=1 in CHECK -> tlb_req_o never 1, no done_o, stalls high exactly 1 cycle.
REQ-033 PROBE with tlb_hit_i=0, tlb_hit_idx_i=7 -> mmc_e_o=1, mmc_idx_o=7; then a hit at idx 12 -> mmc_e_o=0, mmc_idx_o=12.
REQ-034 NUM_ENTRIES=8, INVALI, ack always 1 -> tlb_idx_o 0..7, 8 req cycles; done_o at accept+10; tlb_idx_o never 8.
REQ-035 tlbread_i_m and tlbprobe_i_m together; then READ idx=600 with NUM_ENTRIES=512 -> both mmc_e_o=1 with no tlb_req_o.
REQ-036 reset=0 mid-sweep at idx 3 -> all outputs 0 immediately; no done_o after release; next READ completes normally.
